// File: rtl/screensaver_motion_ctrl.sv
// Bouncing-logo motion sequencer, run once per frame in vblank.
// Steps the logo, reflects at the walls, advances colour on bounce.
module screensaver_motion_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LOGO_W   = 64,
  parameter int LOGO_H   = 32,
  parameter int X_INIT   = 288,
  parameter int Y_INIT   = 224,
  parameter int COLORS   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pause,
  input  logic       frame_start,
  input  logic [2:0] speed,
  output logic [9:0] logo_x,
  output logic [9:0] logo_y,
  output logic [2:0] color_idx,
  output logic       bounce,
  output logic       corner,
  output logic       busy
);

  localparam logic [9:0] X_MAX  = 10'(H_ACTIVE - LOGO_W);
  localparam logic [9:0] Y_MAX  = 10'(V_ACTIVE - LOGO_H);
  localparam logic [9:0] X_RST  = 10'(X_INIT);
  localparam logic [9:0] Y_RST  = 10'(Y_INIT);
  localparam logic [2:0] C_LAST = 3'(COLORS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DONE
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [2:0] cnt;
  logic       dir_x;
  logic       dir_y;
  logic       x_hit;
  logic       y_hit;

  logic       start;
  logic       last;
  logic       x_wall;
  logic       y_wall;
  logic       dir_x_n;
  logic       dir_y_n;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       x_hit_n;
  logic       y_hit_n;
  logic       any_hit;
  logic [2:0] color_inc;

  assign start = frame_start & enable & ~pause
               & (speed != 3'd0);
  assign last  = (cnt == 3'd1);

  // per-axis reflection: a wall flips the direction before stepping
  always_comb begin
    x_wall  = dir_x ? (logo_x == X_MAX) : (logo_x == 10'd0);
    y_wall  = dir_y ? (logo_y == Y_MAX) : (logo_y == 10'd0);
    dir_x_n = dir_x ^ x_wall;
    dir_y_n = dir_y ^ y_wall;
    x_next  = dir_x_n ? logo_x + 10'd1 : logo_x - 10'd1;
    y_next  = dir_y_n ? logo_y + 10'd1 : logo_y - 10'd1;
    x_hit_n = x_hit | x_wall;
    y_hit_n = y_hit | y_wall;
    any_hit = x_hit_n | y_hit_n;
    if (color_idx == C_LAST) begin
      color_inc = 3'd0;
    end else begin
      color_inc = color_idx + 3'd1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = MOVE;
        end
      end
      MOVE: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // motion datapath; bounce/colour resolve on the edge into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      logo_x    <= X_RST;
      logo_y    <= Y_RST;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      color_idx <= 3'd0;
      bounce    <= 1'b0;
      corner    <= 1'b0;
      busy      <= 1'b0;
      x_hit     <= 1'b0;
      y_hit     <= 1'b0;
      cnt       <= 3'd0;
    end else begin
      busy   <= (state_n != IDLE);
      bounce <= 1'b0;
      corner <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt <= speed;
          end
        end
        MOVE: begin
          if (enable) begin
            logo_x <= x_next;
            logo_y <= y_next;
            dir_x  <= dir_x_n;
            dir_y  <= dir_y_n;
            x_hit  <= x_hit_n;
            y_hit  <= y_hit_n;
            cnt    <= cnt - 3'd1;
            if (last) begin
              bounce <= any_hit;
              corner <= x_hit_n & y_hit_n;
              if (any_hit) begin
                color_idx <= color_inc;
              end
            end
          end else begin
            x_hit <= 1'b0;
            y_hit <= 1'b0;
            cnt   <= 3'd0;
          end
        end
        DONE: begin
          x_hit <= 1'b0;
          y_hit <= 1'b0;
        end
        default: begin
          x_hit <= 1'b0;
          y_hit <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_screensaver_motion_ctrl.sv
// Scoreboard bench for screensaver_motion_ctrl.
// Stimulus pushes expected frame results; a monitor pops them.
module tb_screensaver_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b1;
  logic       pause = 1'b0;
  logic       frame_start = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [9:0] logo_x;
  logic [9:0] logo_y;
  logic [2:0] color_idx;
  logic       bounce;
  logic       corner;
  logic       busy;

  screensaver_motion_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .pause(pause),
    .frame_start(frame_start),
    .speed(speed),
    .logo_x(logo_x),
    .logo_y(logo_y),
    .color_idx(color_idx),
    .bounce(bounce),
    .corner(corner),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
    int b;
    int k;
    int len;
  } exp_t;

  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  int mx = 288;
  int my = 224;
  int mc = 0;
  bit mdx = 1'b1;
  bit mdy = 1'b1;
  int nsteps = 0;
  int dut_bounces = 0;
  int dut_corners = 0;
  bit wall_abort_done = 1'b0;

  task automatic chk(string nm, int act, int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic model_reset();
    mx = 288;
    my = 224;
    mc = 0;
    mdx = 1'b1;
    mdy = 1'b1;
    nsteps = 0;
  endtask

  task automatic model_step(output bit hx, output bit hy);
    hx = 1'b0;
    hy = 1'b0;
    if (mdx) begin
      if (mx == 576) begin
        mdx = 1'b0; mx--; hx = 1'b1;
      end else mx++;
    end else begin
      if (mx == 0) begin
        mdx = 1'b1; mx++; hx = 1'b1;
      end else mx--;
    end
    if (mdy) begin
      if (my == 448) begin
        mdy = 1'b0; my--; hy = 1'b1;
      end else my++;
    end else begin
      if (my == 0) begin
        mdy = 1'b1; my++; hy = 1'b1;
      end else my--;
    end
    nsteps++;
  endtask

  // abort_at: cycle of the frame at which enable drops (0 = never)
  // extra_at: cycle at which a stray frame_start is pulsed (0 = never)
  task automatic run_frame(int spd, int abort_at, int extra_at);
    exp_t e;
    bit hx, hy;
    bit ax = 1'b0;
    bit ay = 1'b0;
    bit done = 1'b0;
    int steps;
    steps = (abort_at > 0) ? abort_at - 1 : spd;
    for (int i = 0; i < steps; i++) begin
      model_step(hx, hy);
      ax |= hx;
      ay |= hy;
    end
    if (abort_at > 0) begin
      e = '{mx, my, mc, 0, 0, abort_at};
    end else begin
      if (ax | ay) mc = (mc + 1) % 8;
      e = '{mx, my, mc, int'(ax | ay), int'(ax & ay), spd + 1};
    end
    q.push_back(e);
    @(negedge clk);
    speed = 3'(spd);
    frame_start = 1'b1;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        frame_start = 1'b0;
      end else begin
        frame_start = (i == extra_at);
        if (i == 1) begin
          speed = 3'(spd + 3);
          pause = 1'b1;
        end
        if (i == abort_at) enable = 1'b0;
      end
    end
    chk("frame_end", int'(done), 1);
    enable = 1'b1;
    pause = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic gate_frame(bit p, bit en, int spd);
    bit hb = 1'b0;
    @(negedge clk);
    pause = p;
    enable = en;
    speed = 3'(spd);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    if (busy) hb = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (busy) hb = 1'b1;
    end
    chk("gate_busy", int'(hb), 0);
    chk("gate_x", int'(logo_x), mx);
    chk("gate_y", int'(logo_y), my);
    chk("gate_color", int'(color_idx), mc);
    pause = 1'b0;
    enable = 1'b1;
  endtask

  // monitor: captures the last busy cycle of each frame
  initial begin
    bit pb = 1'b0;
    int len = 0;
    int sx = 0, sy = 0, sc = 0, sb = 0, sk = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pb = 1'b0;
        len = 0;
      end else begin
        if (bounce) dut_bounces++;
        if (corner) dut_corners++;
        if (busy) begin
          len++;
          sx = int'(logo_x);
          sy = int'(logo_y);
          sc = int'(color_idx);
          sb = int'(bounce);
          sk = int'(corner);
        end
        if (pb && !busy) begin
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got len %0d expected none",
                     len);
          end else begin
            e = q.pop_front();
            chk("busy_len", len, e.len);
            chk("x", sx, e.x);
            chk("y", sy, e.y);
            chk("color", sc, e.c);
            chk("bounce", sb, e.b);
            chk("corner", sk, e.k);
          end
          len = 0;
        end
        pb = busy;
      end
    end
  end

  initial begin
    int k = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_x", int'(logo_x), 288);
    chk("rst_y", int'(logo_y), 224);
    chk("rst_color", int'(color_idx), 0);
    chk("rst_bounce", int'(bounce), 0);
    chk("rst_corner", int'(corner), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    run_frame(3, 0, 0);
    chk("free_x", int'(logo_x), 291);
    chk("free_y", int'(logo_y), 227);
    chk("free_color", int'(color_idx), 0);

    @(negedge clk);
    speed = 3'd7;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_x", int'(logo_x), 288);
    chk("midrst_y", int'(logo_y), 224);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_color", int'(color_idx), 0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;

    gate_frame(1'b1, 1'b1, 3);
    gate_frame(1'b0, 1'b1, 0);
    gate_frame(1'b0, 1'b0, 5);

    run_frame(4, 0, 2);
    run_frame(5, 0, 6);
    run_frame(6, 3, 0);
    run_frame(1, 0, 0);

    while (nsteps < 2480) begin
      if (!wall_abort_done && mdx && mx >= 571) begin
        run_frame(7, 7, 0);
        wall_abort_done = 1'b1;
      end else begin
        run_frame(1 + (k % 7), 0, 0);
        k++;
      end
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("total_bounces", dut_bounces, 8);
    chk("total_corners", dut_corners, 1);
    chk("final_color", int'(color_idx), 0);
    chk("final_x", int'(logo_x), mx);
    chk("final_y", int'(logo_y), my);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/screensaver_motion_ctrl.md
Name: screensaver_motion_ctrl

Overview:
Per-frame motion sequencer for the bouncing-logo screensaver datapath. It is triggered once per frame by the VGA timing block during vertical blanking. It steps the logo position one pixel per cycle for a programmable number of steps, reflects the direction at the screen edges, and advances the logo colour index on every bounce. Its outputs feed the pixel/colour generator that drives r, g and b.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
LOGO_W, 64, logo width in pixels
LOGO_H, 32, logo height in pixels
X_INIT, 288, logo_x after reset; must satisfy 0 <= X_INIT <= H_ACTIVE-LOGO_W
Y_INIT, 224, logo_y after reset; must satisfy 0 <= Y_INIT <= V_ACTIVE-LOGO_H
COLORS, 8, number of palette entries; colour index wraps modulo COLORS

Ports:
clk  in  1  pixel clock (25.175 MHz); single clock domain
rst_n  in  1  asynchronous, active-low reset
enable  in  1  motion enable
pause  in  1  freeze motion; sampled only in IDLE
frame_start  in  1  one-cycle pulse from the timing block at start of vblank
speed  in  3  pixels moved per axis per frame; 0 = frozen; sampled on frame_start
logo_x  out  10  logo left edge, range 0..H_ACTIVE-LOGO_W
logo_y  out  10  logo top edge, range 0..V_ACTIVE-LOGO_H
color_idx  out  3  current palette index
bounce  out  1  one-cycle pulse: at least one wall hit this frame
corner  out  1  one-cycle pulse: both an x and a y wall hit this frame
busy  out  1  high while state != IDLE

Behaviour:
- Reset (asynchronous, immediate, any state):
  - logo_x=X_INIT, logo_y=Y_INIT, dir_x=+, dir_y=+, color_idx=0.
  - bounce=0, corner=0, busy=0, hit flags cleared, step counter=0, state=IDLE.
- States: IDLE, MOVE, DONE. All outputs are registered.
- IDLE -> MOVE when frame_start & enable & !pause & speed!=0:
  - Load step counter with speed.
  - Otherwise stay in IDLE; frame_start is dropped and nothing changes.
- MOVE: every cycle, one step on each axis, then decrement the counter; -> DONE after the cycle in which the counter reaches 0. MOVE therefore lasts exactly speed cycles.
- X-axis step rule (Y identical with V_ACTIVE/LOGO_H):
  - dir_x=+, logo_x < H_ACTIVE-LOGO_W: logo_x+1.
  - dir_x=+, logo_x == H_ACTIVE-LOGO_W: flip dir_x to -, logo_x-1, set x_hit.
  - dir_x=-, logo_x > 0: logo_x-1.
  - dir_x=-, logo_x == 0: flip dir_x to +, logo_x+1, set x_hit.
  - Position never leaves the legal range; no arithmetic wrap.
- DONE (exactly 1 cycle), then -> IDLE:
  - bounce = x_hit|y_hit.
  - corner = x_hit&y_hit.
  - color_idx = (color_idx+1) mod COLORS if bounce.
  - Hit flags are cleared on exit.
- Timing: frame_start at cycle T gives MOVE in T+1..T+speed, DONE at T+speed+1, and bounce/corner high only during DONE.
- Boundary and simultaneous-event rules:
  - frame_start while in MOVE or DONE is ignored; no queueing.
  - speed and pause changes during MOVE have no effect until the next frame.
  - enable low during MOVE or DONE: -> IDLE at the next edge, position and direction kept, hit flags discarded, no bounce pulse, colour unchanged.
  - Multiple hits on one axis within a frame count as one bounce.
- Positions change only in MOVE. Because frame_start arrives at vblank and a frame needs at most 8 busy cycles, positions are stable during active video.

Test Plan:
1. Reset: hold rst_n=0, then release -> logo_x=288, logo_y=224, color_idx=0, bounce=corner=busy=0. Assert rst_n=0 mid-MOVE -> same values immediately, without waiting for a clock edge.
2. Free motion: speed=3, pulse frame_start -> busy high for 4 cycles (3 MOVE + DONE); afterwards logo_x=291, logo_y=227, bounce=0, color_idx=0.
3. Right wall: X_INIT=574, speed=4, one frame -> x steps 575, 576, 575, 574; dir_x becomes -; y ends at 228; bounce pulses 1 cycle, corner=0, color_idx=1.
4. Corner: X_INIT=575, Y_INIT=447, speed=2 -> x steps 576, 575 and y steps 448, 447; bounce=1 and corner=1 in the same cycle; color_idx=1.
5. Colour wrap: drive 8 bounce frames from color_idx=0 -> index sequence 1..7 then 0; exactly 8 bounce pulses.
6. Gating: each case below leaves position and colour unchanged.
   - pause=1 with frame_start -> busy stays 0.
   - speed=0 with frame_start -> busy stays 0.
   - frame_start during MOVE -> ignored; MOVE length unchanged.
   - enable=0 mid-MOVE -> IDLE next cycle, no bounce even if a wall was hit.
